spdif_tx_core: RTL and testbench
================================

Name: spdif_tx_core

Overview:
- Parametrised IEC 60958 (S/PDIF) transmitter; the next-generation TX path of the audio subsystem.
- Buffers stereo PCM pairs in an internal FIFO and builds full subframes: preambles B/M/W, 24-bit audio slot, V/U/C/P bits and a 192-frame channel-status block.
- Emits a biphase-mark-coded (BMC) line, paced by an external unit-interval (UI) tick.
- Sits between the audio DMA/PCM mux and the S/PDIF pad.

Parameters:
SAMPLE_W, 24, audio sample width in bits, legal 16..24, MSB-aligned into the 24-bit audio field
FIFO_DEPTH, 8, stereo-pair FIFO entries, power of 2, >=2
CS_W, 40, number of leading channel-status bits supplied by port; frames >= CS_W send C=0; legal 1..192

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
enable  in  1  transmitter run; low = line idle, framing counters cleared
ui_tick  in  1  one-clk pulse per UI (128 UI per frame, i.e. 128*fs)
s_valid  in  1  input pair valid
s_ready  out  1  FIFO can accept (=!full)
s_left  in  SAMPLE_W  left sample, two's complement
s_right  in  SAMPLE_W  right sample
cs_bits  in  CS_W  channel-status bits; bit i sent in frame i of block
underrun_clr  in  1  clears underrun flag
underrun  out  1  sticky: frame started with FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
block_start  out  1  one-clk pulse when frame 0 (B preamble) begins
spdif_tx  out  1  BMC line output

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high, on port rst.
  - Reset values: spdif_tx=0, s_ready=1, fifo_level=0, underrun=0, block_start=0.
  - Reset also clears FIFO pointers, ui_cnt and frame_cnt.
  - Reset mid-frame aborts the frame; the next clk shows spdif_tx=0.
- FIFO:
  - Push when s_valid&&s_ready; entry = {left,right}.
  - s_ready and fifo_level are registered, updated the clk after the push/pop.
  - Full: push refused.
  - Push and pop in the same cycle: level unchanged; when empty, no bypass, so the pop sees empty.
  - FIFO contents are retained while enable=0.
- Counters:
  - ui_cnt is 7 bits, 0..127. ui_cnt[6] selects subframe (0=left, 1=right), ui_cnt[5:1] is time slot 0..31, ui_cnt[0] is the half-slot.
  - frame_cnt runs 0..191 and wraps to 0.
  - Counters advance only on ui_tick while enable=1.
  - enable low: ui_cnt=0, frame_cnt=0, spdif_tx forced 0.
  - The first ui_tick after enable rises drives UI 0 of frame 0.
- Frame load:
  - Happens on the ui_tick with ui_cnt==127, and also on the first tick after enable.
  - If the FIFO is non-empty, pop into hold regs with V=0.
  - Else load zeros with V=1 and set underrun; the flag stays until underrun_clr, and a set in the same cycle wins over the clear.
- Subframe contents:
  - Slots 4..27: 24-bit audio, LSB in slot 4. The sample occupies slots 28-SAMPLE_W..27; lower slots are 0.
  - Slot 28=V, slot 29=U (always 0), slot 30=C, slot 31=P.
  - C = cs_bits[frame_cnt] if frame_cnt<CS_W, else 0; the same C goes in both subframes.
  - P gives even parity over slots 4..31.
- Preambles (slots 0-3, 8 UI), written for a preceding line level of 0:
  - B = 11101000, used in the left subframe of frame 0.
  - M = 11100010, used in the left subframe otherwise.
  - W = 11100100, used in the right subframe.
  - If the line level before the preamble is 1, transmit the inverted pattern.
- BMC (slots 4..31): spdif_tx toggles at the first half of every slot, and toggles again at the second half iff the bit is 1.
- Output timing:
  - spdif_tx is registered and updates on the clk where ui_tick=1.
  - block_start pulses on the tick that drives UI 0 of frame 0.
- ui_tick asserted in consecutive clks is legal, so the design needs no multi-cycle assumptions.

Test Plan:
- Reset: assert rst 3 clks with enable=1 -> spdif_tx=0, s_ready=1, fifo_level=0, underrun=0.
- Pair framing: push left=24'h000001, right=24'h800000, cs_bits[0]=1, enable, tick 128 UI, BMC-decode the line -> frame 0 decodes as:
  - Left subframe: preamble B, slot 4=1, slots 5..27=0, V=0, U=0, C=1, P=0, block_start pulse seen.
  - Right subframe: preamble W, slot 27=1 only, C=1, P=0.
- Width: SAMPLE_W=16, left=16'h0001 -> slot 12=1, slots 4..11=0.
- Underrun: enable with empty FIFO -> underrun=1 after the first load; audio=0 and V=1 in both subframes; underrun_clr clears it; a later push gives V=0 on the next frame.
- Full: FIFO_DEPTH=4, ui_tick=0, push 5 pairs back-to-back -> fifo_level=4, s_ready=0 after the 4th, 5th pair dropped, no level change.
- Block wrap and reset: run 193 frames -> block_start at frames 0 and 192, with preamble B at frame 192 and preamble M at frames 1..191. Then pulse rst mid-subframe -> spdif_tx=0 the next clk, fifo_level=0, and restart begins with preamble B.

Source files
------------

// File: rtl/spdif_tx_core.sv
// IEC 60958 transmitter: stereo-pair FIFO, subframe builder (preambles, audio, V/U/C/P)
// and biphase-mark line coder paced by an external unit-interval tick.
module spdif_tx_core #(
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int CS_W       = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          ui_tick,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_left,
  input  logic [SAMPLE_W-1:0]           s_right,
  input  logic [CS_W-1:0]               cs_bits,
  input  logic                          underrun_clr,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          block_start,
  output logic                          spdif_tx
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PAD = 24 - SAMPLE_W;
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level_next;
  logic [2*SAMPLE_W-1:0] pop_data;
  logic                  push, pop, load, fifo_empty;

  logic [6:0]  ui_cnt;
  logic [7:0]  frame_cnt, frame_next;
  logic        started;
  logic [23:0] left_q, right_q, aud;
  logic        v_q, c_q, pre_inv_q, c_next;
  logic [4:0]  slot;
  logic [7:0]  pat;
  logic        data_bit, pre_bit, inv, par, tx_next;

  assign fifo_empty = (fifo_level == '0);
  assign push       = s_valid && s_ready;
  // ui_cnt holds the UI the next tick will drive; a load refills the hold regs for the next frame
  assign load       = enable && ui_tick && (!started || ui_cnt == 7'd127);
  assign pop        = load && !fifo_empty;
  assign pop_data   = mem[rd_ptr];
  assign frame_next = (!started || frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;

  always_comb begin
    c_next = 1'b0;
    for (int i = 0; i < CS_W; i++)
      if (frame_next == 8'(i)) c_next = cs_bits[i];
  end

  always_comb begin
    level_next = fifo_level;
    if (push && !pop)      level_next = fifo_level + 1'b1;
    else if (pop && !push) level_next = fifo_level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_left, s_right};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_next;
      s_ready    <= (level_next != (AW+1)'(FIFO_DEPTH));
    end
  end

  assign slot = ui_cnt[5:1];
  assign aud  = ui_cnt[6] ? right_q : left_q;
  assign par  = ^{aud, v_q, c_q};
  assign pat  = ui_cnt[6] ? PRE_W : ((frame_cnt == 8'd0) ? PRE_B : PRE_M);
  assign pre_bit = pat[3'd7 - ui_cnt[2:0]];
  assign inv  = (ui_cnt[2:0] == 3'd0) ? spdif_tx : pre_inv_q;

  always_comb begin
    data_bit = 1'b0;
    if (slot >= 5'd4 && slot <= 5'd27) data_bit = aud[slot - 5'd4];
    else if (slot == 5'd28)            data_bit = v_q;
    else if (slot == 5'd30)            data_bit = c_q;
    else if (slot == 5'd31)            data_bit = par;
  end

  always_comb begin
    if (slot < 5'd4)    tx_next = pre_bit ^ inv;
    else if (!ui_cnt[0]) tx_next = ~spdif_tx;
    else                tx_next = data_bit ? ~spdif_tx : spdif_tx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ui_cnt      <= '0;
      frame_cnt   <= '0;
      started     <= 1'b0;
      spdif_tx    <= 1'b0;
      block_start <= 1'b0;
      pre_inv_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      v_q         <= 1'b0;
      c_q         <= 1'b0;
    end else if (!enable) begin
      ui_cnt      <= '0;
      frame_cnt   <= '0;
      started     <= 1'b0;
      spdif_tx    <= 1'b0;
      block_start <= 1'b0;
    end else begin
      block_start <= 1'b0;
      if (ui_tick) begin
        spdif_tx    <= tx_next;
        block_start <= (ui_cnt == 7'd0) && (frame_cnt == 8'd0);
        started     <= 1'b1;
        ui_cnt      <= ui_cnt + 7'd1;
        if (ui_cnt[5:0] == 6'd0) pre_inv_q <= spdif_tx;
        if (ui_cnt == 7'd127) frame_cnt <= frame_next;
      end
      if (load) begin
        c_q <= c_next;
        if (pop) begin
          left_q  <= 24'(pop_data[2*SAMPLE_W-1:SAMPLE_W]) << PAD;
          right_q <= 24'(pop_data[SAMPLE_W-1:0]) << PAD;
          v_q     <= 1'b0;
        end else begin
          left_q  <= '0;
          right_q <= '0;
          v_q     <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    underrun <= 1'b0;
    else if (load && fifo_empty) underrun <= 1'b1;
    else if (underrun_clr)      underrun <= 1'b0;
  end

endmodule

// File: tb/tb_spdif_tx_core.sv
// Directed bench for spdif_tx_core: two instances (24-bit/depth 8 and 16-bit/depth 4),
// line captured per frame and decoded back into preambles and slot bits.
module tb_spdif_tx_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, tick_a, valid_a, ready_a, uclr_a, under_a, bs_a, tx_a;
  logic [23:0] left_a, right_a;
  logic [39:0] cs_a;
  logic [3:0]  lvl_a;

  logic        rst_b, en_b, tick_b, valid_b, ready_b, uclr_b, under_b, bs_b, tx_b;
  logic [15:0] left_b, right_b;
  logic [7:0]  cs_b;
  logic [2:0]  lvl_b;

  spdif_tx_core #(.SAMPLE_W(24), .FIFO_DEPTH(8), .CS_W(40)) u_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .ui_tick(tick_a), .s_valid(valid_a),
    .s_ready(ready_a), .s_left(left_a), .s_right(right_a), .cs_bits(cs_a),
    .underrun_clr(uclr_a), .underrun(under_a), .fifo_level(lvl_a),
    .block_start(bs_a), .spdif_tx(tx_a));

  spdif_tx_core #(.SAMPLE_W(16), .FIFO_DEPTH(4), .CS_W(8)) u_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .ui_tick(tick_b), .s_valid(valid_b),
    .s_ready(ready_b), .s_left(left_b), .s_right(right_b), .cs_bits(cs_b),
    .underrun_clr(uclr_b), .underrun(under_b), .fifo_level(lvl_b),
    .block_start(bs_b), .spdif_tx(tx_b));

  int   n_cmp = 0;
  int   n_bad = 0;
  logic lv [128];
  logic prev_lv, bs_seen0, bs_other, und_mid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit b);
    if (b) tick_b = 1'b1; else tick_a = 1'b1;
    clk1();
    tick_a = 1'b0;
    tick_b = 1'b0;
  endtask

  task automatic run_frame(input bit b);
    prev_lv  = b ? tx_b : tx_a;
    bs_seen0 = 1'b0;
    bs_other = 1'b0;
    und_mid  = 1'b0;
    for (int i = 0; i < 128; i++) begin
      tick(b);
      lv[i] = b ? tx_b : tx_a;
      if (b ? bs_b : bs_a) begin
        if (i == 0) bs_seen0 = 1'b1;
        else        bs_other = 1'b1;
      end
      if (i == 64) und_mid = b ? under_b : under_a;
    end
  endtask

  function automatic logic [7:0] pre(input bit right);
    logic [7:0] p;
    logic       lvl;
    int         base;
    base = right ? 64 : 0;
    lvl  = right ? lv[63] : prev_lv;
    for (int k = 0; k < 8; k++) p[7-k] = lv[base+k];
    return p ^ {8{lvl}};
  endfunction

  function automatic logic [27:0] bits(input bit right);
    logic [27:0] r;
    int          base;
    base = right ? 64 : 0;
    for (int s = 4; s < 32; s++) r[s-4] = lv[base+2*s] ^ lv[base+2*s+1];
    return r;
  endfunction

  function automatic logic bmc_ok(input bit right);
    logic ok;
    int   base;
    base = right ? 64 : 0;
    ok   = 1'b1;
    for (int s = 4; s < 32; s++)
      if (lv[base+2*s] == lv[base+2*s-1]) ok = 1'b0;
    return ok;
  endfunction

  task automatic push_a(input logic [23:0] l, input logic [23:0] r);
    valid_a = 1'b1; left_a = l; right_a = r;
    clk1();
    valid_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b1; tick_a = 1'b0; valid_a = 1'b0; uclr_a = 1'b0;
    left_a = '0; right_a = '0; cs_a = 40'h1;
    rst_b = 1'b1; en_b = 1'b0; tick_b = 1'b0; valid_b = 1'b0; uclr_b = 1'b0;
    left_b = '0; right_b = '0; cs_b = 8'h00;
    repeat (3) clk1();
    chk("rst_tx", {31'd0, tx_a}, 32'd0);
    chk("rst_ready", {31'd0, ready_a}, 32'd1);
    chk("rst_level", {28'd0, lvl_a}, 32'd0);
    chk("rst_underrun", {31'd0, under_a}, 32'd0);
    chk("rst_bstart", {31'd0, bs_a}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0;

    // 16-bit / depth-4 instance: fill past full, then check width alignment and drop
    valid_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      left_b = 16'd1 << k; right_b = 16'h8000;
      clk1();
      chk("full_level", {29'd0, lvl_b}, (k < 4) ? k + 1 : 4);
      chk("full_ready", {31'd0, ready_b}, (k < 3) ? 32'd1 : 32'd0);
    end
    valid_b = 1'b0;
    en_b = 1'b1;
    run_frame(1'b1);
    chk("w16_left", {4'd0, bits(1'b0)}, 32'h8000100);
    chk("w16_right", {4'd0, bits(1'b1)}, 32'h8800000);
    run_frame(1'b1);
    run_frame(1'b1);
    chk("drop_no_underrun", {31'd0, under_b}, 32'd0);
    run_frame(1'b1);
    chk("w16_pair4_left", {4'd0, bits(1'b0)}, 32'h8000800);
    chk("drop_underrun", {31'd0, under_b}, 32'd1);

    // main instance: pair framing in frame 0
    push_a(24'h000001, 24'h800000);
    chk("push_level", {28'd0, lvl_a}, 32'd1);
    en_a = 1'b1;
    run_frame(1'b0);
    chk("f0_pre_left", {24'd0, pre(1'b0)}, 32'hE8);
    chk("f0_bits_left", {4'd0, bits(1'b0)}, 32'h4000001);
    chk("f0_bmc_left", {31'd0, bmc_ok(1'b0)}, 32'd1);
    chk("f0_pre_right", {24'd0, pre(1'b1)}, 32'hE4);
    chk("f0_bits_right", {4'd0, bits(1'b1)}, 32'h4800000);
    chk("f0_bmc_right", {31'd0, bmc_ok(1'b1)}, 32'd1);
    chk("f0_bstart", {31'd0, bs_seen0}, 32'd1);
    chk("f0_bstart_extra", {31'd0, bs_other}, 32'd0);
    chk("f0_underrun_mid", {31'd0, und_mid}, 32'd0);
    chk("f0_level", {28'd0, lvl_a}, 32'd0);
    chk("f1_underrun_set", {31'd0, under_a}, 32'd1);

    // underrun frame: zero audio, V=1, P=1
    run_frame(1'b0);
    chk("f1_pre_left", {24'd0, pre(1'b0)}, 32'hE2);
    chk("f1_bits_left", {4'd0, bits(1'b0)}, 32'h9000000);
    chk("f1_bits_right", {4'd0, bits(1'b1)}, 32'h9000000);
    uclr_a = 1'b1;
    clk1();
    uclr_a = 1'b0;
    chk("underrun_clr", {31'd0, under_a}, 32'd0);
    push_a(24'h123456, 24'hABCDEF);
    run_frame(1'b0);
    chk("f2_no_underrun", {31'd0, under_a}, 32'd0);
    chk("f2_level", {28'd0, lvl_a}, 32'd0);
    run_frame(1'b0);
    chk("f3_pre_left", {24'd0, pre(1'b0)}, 32'hE2);
    chk("f3_bits_left", {4'd0, bits(1'b0)}, 32'h8123456);
    chk("f3_bits_right", {4'd0, bits(1'b1)}, 32'h8ABCDEF);
    chk("f3_bmc_right", {31'd0, bmc_ok(1'b1)}, 32'd1);

    for (int f = 4; f < 192; f++) begin
      run_frame(1'b0);
      chk("mid_pre_M", {24'd0, pre(1'b0)}, 32'hE2);
      chk("mid_no_bstart", {30'd0, bs_seen0, bs_other}, 32'd0);
    end
    run_frame(1'b0);
    chk("f192_pre_B", {24'd0, pre(1'b0)}, 32'hE8);
    chk("f192_bstart", {31'd0, bs_seen0}, 32'd1);

    // abort mid-subframe with a pair queued
    push_a(24'h00FFFF, 24'h000000);
    for (int i = 0; i < 41; i++) tick(1'b0);
    chk("pre_reset_line", {31'd0, tx_a}, 32'd1);
    rst_a = 1'b1;
    clk1();
    chk("midrst_tx", {31'd0, tx_a}, 32'd0);
    chk("midrst_level", {28'd0, lvl_a}, 32'd0);
    rst_a = 1'b0;
    run_frame(1'b0);
    chk("restart_pre_B", {24'd0, pre(1'b0)}, 32'hE8);
    chk("restart_bstart", {31'd0, bs_seen0}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
